// File: rtl/mic1_pkg.sv
// Shared constants, FSM state encoding and the MBR byte-lane selector
// used by the Mic-1 memory interface.
package mic1_pkg;

  localparam int MEM_WR    = 2;
  localparam int MEM_RD    = 1;
  localparam int MEM_FETCH = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } mem_state_e;

  // Big-endian: byte offset 0 is the most significant lane of the word.
  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  idx,
                                          input logic        big_endian);
    logic [1:0] lane;
    lane = big_endian ? ~idx : idx;
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mic1_fetch_buf.sv
// One-word opcode fetch buffer: holds the last fetched word with its word tag.
// An invalidate for the tagged word wins over a same-cycle refill.
module mic1_fetch_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic [29:0] lookup_tag,
  output logic        hit,
  output logic [31:0] rd_word,
  input  logic        fill_en,
  input  logic [29:0] fill_tag,
  input  logic [31:0] fill_word,
  input  logic        inv_en,
  input  logic [29:0] inv_tag
);

  logic        valid_q;
  logic [29:0] tag_q;
  logic [31:0] data_q;
  logic [29:0] next_tag;

  assign next_tag = fill_en ? fill_tag : tag_q;
  assign hit      = valid_q && (tag_q == lookup_tag);
  assign rd_word  = data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (fill_en) begin
        valid_q <= 1'b1;
        tag_q   <= fill_tag;
        data_q  <= fill_word;
      end
      if (inv_en && (inv_tag == next_tag)) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mic1_mem_ctrl.sv
// Mic-1 memory interface: runs the {write, read, fetch} ops of a microinstruction
// on one memory port and stalls the sequencer. Optional fetch buffer: FETCH_BUF_EN.
module mic1_mem_ctrl
  import mic1_pkg::*;
#(
  parameter bit MAR_WORD_ADDR    = 1'b1,
  parameter bit FETCH_BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  mem_ctrl,
  input  logic [31:0] mar,
  input  logic [31:0] mdr_out,
  input  logic [31:0] pc,
  output logic        stall,
  output logic [31:0] mdr_in,
  output logic        mdr_load,
  output logic [7:0]  mbr_in,
  output logic        mbr_load,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_DATA  = ST_DATA;
  localparam logic [1:0] S_FETCH = ST_FETCH;

  logic [1:0]  state_q;
  logic        rd_q, fetch_q, we_q, err_q, hit_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [7:0]  hit_byte_q;

  logic [31:0] byte_addr, data_addr, pc_word, buf_word;
  logic        busy, done, final_op, stall_int, accept;
  logic        fetch_only, buf_hit, data_done, fetch_done;

  assign byte_addr  = MAR_WORD_ADDR ? (mar << 2) : mar;
  assign data_addr  = byte_addr & ~32'h3;
  assign pc_word    = pc & ~32'h3;
  assign fetch_only = (mem_ctrl == 3'b001);

  // mem_req/mem_ready: a transfer completes at the posedge where both are high;
  // mem_addr, mem_we and mem_wdata are held unchanged until that edge.
  assign busy      = (state_q != S_IDLE);
  assign done      = busy && mem_ready;
  assign final_op  = (state_q == S_FETCH) || ((state_q == S_DATA) && !fetch_q);
  assign stall_int = busy && !(mem_ready && final_op);
  assign accept    = (mem_ctrl != 3'b000) && !stall_int;

  assign data_done  = resetn && done && (state_q == S_DATA) && rd_q;
  assign fetch_done = resetn && done && (state_q == S_FETCH);

`ifdef FETCH_BUF_EN
  logic buf_hit_raw;

  mic1_fetch_buf u_fetch_buf (
    .clk        (clk),
    .resetn     (resetn),
    .lookup_tag (pc[31:2]),
    .hit        (buf_hit_raw),
    .rd_word    (buf_word),
    .fill_en    (fetch_done),
    .fill_tag   (pc_q[31:2]),
    .fill_word  (mem_rdata),
    .inv_en     (accept && mem_ctrl[MEM_WR]),
    .inv_tag    (data_addr[31:2])
  );

  assign buf_hit = fetch_only && buf_hit_raw;
`else
  assign buf_hit  = 1'b0;
  assign buf_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      fetch_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      hit_byte_q <= '0;
    end else begin
      hit_q <= 1'b0;
      if (accept) begin
        // Write+read is illegal: the write goes ahead and the read is dropped.
        err_q   <= err_q | (mem_ctrl[MEM_WR] & mem_ctrl[MEM_RD]);
        rd_q    <= mem_ctrl[MEM_RD] & ~mem_ctrl[MEM_WR];
        fetch_q <= mem_ctrl[MEM_FETCH];
        pc_q    <= pc;
        wdata_q <= mdr_out;
        if (mem_ctrl[MEM_WR] || mem_ctrl[MEM_RD]) begin
          state_q <= S_DATA;
          addr_q  <= data_addr;
          we_q    <= mem_ctrl[MEM_WR];
        end else if (buf_hit) begin
          state_q    <= S_IDLE;
          we_q       <= 1'b0;
          hit_q      <= 1'b1;
          hit_byte_q <= byte_sel(buf_word, pc[1:0], FETCH_BIG_ENDIAN);
        end else begin
          state_q <= S_FETCH;
          addr_q  <= pc_word;
          we_q    <= 1'b0;
        end
      end else if (done) begin
        we_q <= 1'b0;
        if ((state_q == S_DATA) && fetch_q) begin
          state_q <= S_FETCH;
          addr_q  <= pc_q & ~32'h3;
        end else begin
          state_q <= S_IDLE;
        end
      end
    end
  end

  assign stall     = resetn && stall_int;
  assign mem_req   = resetn && busy;
  assign mem_we    = resetn && busy && we_q;
  assign mem_addr  = resetn ? addr_q : '0;
  assign mem_wdata = resetn ? wdata_q : '0;
  assign err       = resetn && err_q;

  assign mdr_load = data_done;
  assign mdr_in   = data_done ? mem_rdata : '0;
  assign mbr_load = fetch_done || (resetn && hit_q);
  always_comb begin
    mbr_in = 8'h00;
    if (fetch_done) begin
      mbr_in = byte_sel(mem_rdata, pc_q[1:0], FETCH_BIG_ENDIAN);
    end else if (resetn && hit_q) begin
      mbr_in = hit_byte_q;
    end
  end

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Randomized scoreboard bench for mic1_mem_ctrl: a behavioural memory and
// command model feeds expected transfers, MDR words and MBR bytes into queues.
`timescale 1ns/1ps
module tb_mic1_mem_ctrl;

  localparam bit MAR_WORD_ADDR    = 1'b1;
  localparam bit FETCH_BIG_ENDIAN = 1'b1;
`ifdef FETCH_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  mem_ctrl;
  logic [31:0] mar, mdr_out, pc;
  logic        stall, mdr_load, mbr_load, err;
  logic [31:0] mdr_in;
  logic [7:0]  mbr_in;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mic1_mem_ctrl #(
    .MAR_WORD_ADDR    (MAR_WORD_ADDR),
    .FETCH_BIG_ENDIAN (FETCH_BIG_ENDIAN)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_ctrl  (mem_ctrl),
    .mar       (mar),
    .mdr_out   (mdr_out),
    .pc        (pc),
    .stall     (stall),
    .mdr_in    (mdr_in),
    .mdr_load  (mdr_load),
    .mbr_in    (mbr_in),
    .mbr_load  (mbr_load),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;

  logic [65:0] exp_txn_q[$];   // {last, we, addr, wdata}
  logic [31:0] exp_mdr_q[$];
  logic [7:0]  exp_mbr_q[$];
  logic        exp_err = 1'b0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem_arr [logic [31:0]];
  logic        mbuf_valid = 1'b0;
  logic [31:0] mbuf_tag = '0;
  logic [31:0] mbuf_data = '0;

  int min_wait = 0;
  int max_wait = 0;
  bit hold_ready = 1'b0;
  bit in_xfer = 1'b0;
  int wleft = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (!ref_mem.exists(a)) ref_mem[a] = init_word(a);
    return ref_mem[a];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem_arr.exists(a)) mem_arr[a] = init_word(a);
    return mem_arr[a];
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input int k);
    logic [31:0] s;
    s = FETCH_BIG_ENDIAN ? (w >> (8 * (3 - k))) : (w >> (8 * k));
    return s[7:0];
  endfunction

  // Reference model: what one accepted command must do to memory, MDR and MBR.
  task automatic model_cmd(input logic [2:0] c, input logic [31:0] m, d, p);
    logic [31:0] a, w, pw;
    a  = MAR_WORD_ADDR ? m * 4 : m;
    w  = a - (a % 4);
    pw = p - (p % 4);
    if (c[2] && c[1]) exp_err = 1'b1;
    if (c[2]) begin
      exp_txn_q.push_back({~c[0], 1'b1, w, d});
      ref_mem[w] = d;
      if (mbuf_valid && mbuf_tag == w) mbuf_valid = 1'b0;
    end else if (c[1]) begin
      exp_txn_q.push_back({~c[0], 1'b0, w, 32'h0});
      exp_mdr_q.push_back(ref_word(w));
    end
    if (c[0]) begin
      if (BUF_EN && c == 3'b001 && mbuf_valid && mbuf_tag == pw) begin
        exp_mbr_q.push_back(pick_byte(mbuf_data, int'(p % 4)));
      end else begin
        exp_txn_q.push_back({1'b1, 1'b0, pw, 32'h0});
        exp_mbr_q.push_back(pick_byte(ref_word(pw), int'(p % 4)));
        mbuf_valid = 1'b1;
        mbuf_tag   = pw;
        mbuf_data  = ref_word(pw);
      end
    end
  endtask

  // ---------------- memory responder ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      in_xfer   = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end else if (mem_req) begin
      if (!in_xfer) begin
        in_xfer = 1'b1;
        wleft   = $urandom_range(max_wait, min_wait);
      end
      if (wleft == 0 && !hold_ready) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word(mem_addr);
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        in_xfer = 1'b0;
      end else begin
        mem_ready = 1'b0;
        if (wleft > 0) wleft--;
        mem_rdata = $urandom;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  // ---------------- monitor ----------------
  always begin
    logic [65:0] t;
    @(negedge clk);
    #3;
    if (!resetn) begin
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_mdr_load", {31'b0, mdr_load}, 32'h0);
      chk("rst_mbr_load", {31'b0, mbr_load}, 32'h0);
      chk("rst_err", {31'b0, err}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
    end else begin
      if (mem_req) begin
        if (exp_txn_q.size() == 0) begin
          chk("req_without_cmd", {31'b0, mem_req}, 32'h0);
        end else begin
          t = exp_txn_q[0];
          chk("stall_busy", {31'b0, stall}, {31'b0, ~(mem_ready & t[65])});
          if (mem_ready) begin
            void'(exp_txn_q.pop_front());
            chk("mem_addr", mem_addr, t[63:32]);
            chk("mem_we", {31'b0, mem_we}, {31'b0, t[64]});
            if (t[64]) chk("mem_wdata", mem_wdata, t[31:0]);
          end
        end
      end else begin
        chk("stall_idle", {31'b0, stall}, 32'h0);
      end
      if (mdr_load) begin
        if (exp_mdr_q.size() == 0) chk("unexpected_mdr_load", {31'b0, mdr_load}, 32'h0);
        else chk("mdr_in", mdr_in, exp_mdr_q.pop_front());
      end
      if (mbr_load) begin
        if (exp_mbr_q.size() == 0) chk("unexpected_mbr_load", {31'b0, mbr_load}, 32'h0);
        else chk("mbr_in", {24'b0, mbr_in}, {24'b0, exp_mbr_q.pop_front()});
      end
      chk("err", {31'b0, err}, {31'b0, exp_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      mem_ctrl = stall ? 3'($urandom_range(1, 7)) : 3'b000;
      @(posedge clk);
    end
  endtask

  // Junk commands are driven while stall is high; they must be ignored.
  task automatic issue(input logic [2:0] c, input logic [31:0] m, d, p);
    bit sent;
    sent = 1'b0;
    for (int n = 0; n < 60 && !sent; n++) begin
      @(negedge clk);
      #1;
      if (resetn && !stall) begin
        mem_ctrl = c;
        mar      = m;
        mdr_out  = d;
        pc       = p;
        @(posedge clk);
        model_cmd(c, m, d, p);
        sent = 1'b1;
      end else begin
        mem_ctrl = 3'($urandom_range(1, 7));
        mar      = $urandom;
        mdr_out  = $urandom;
        pc       = $urandom;
        @(posedge clk);
      end
    end
    if (!sent) fail_now("issue_timeout");
  endtask

  task automatic set_wait(input int lo, input int hi);
    min_wait = lo;
    max_wait = hi;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    mem_ctrl  = 3'b000;
    mar       = '0;
    mdr_out   = '0;
    pc        = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 resetn = 1'b1;
    idle_cycles(2);

    // zero-wait read of MAR word 0x10
    set_wait(0, 0);
    issue(3'b010, 32'h10, 32'h0, 32'h0);
    idle_cycles(2);

    // write then fetch with wait states
    set_wait(2, 2);
    issue(3'b101, 32'h7, 32'h1234_5678, 32'h103);
    idle_cycles(8);

    // illegal write+read, then read back the written word
    set_wait(1, 1);
    issue(3'b110, 32'h9, 32'hDEAD_BEEF, 32'h0);
    idle_cycles(4);
    set_wait(0, 0);
    issue(3'b010, 32'h9, 32'h0, 32'h0);
    idle_cycles(2);

    // reset during a DATA wait abandons the read
    hold_ready = 1'b1;
    issue(3'b010, 32'h5, 32'h0, 32'h0);
    idle_cycles(2);
    @(negedge clk);
    #1;
    resetn   = 1'b0;
    mem_ctrl = 3'b000;
    exp_txn_q.delete();
    exp_mdr_q.delete();
    exp_mbr_q.delete();
    exp_err    = 1'b0;
    mbuf_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    resetn     = 1'b1;
    hold_ready = 1'b0;
    @(posedge clk);
    idle_cycles(4);

    // fetch buffer hit, then invalidate by a write to the same word
    set_wait(0, 1);
    issue(3'b001, 32'h0, 32'h0, 32'h200);
    issue(3'b001, 32'h0, 32'h0, 32'h201);
    issue(3'b100, 32'h80, 32'hCAFE_F00D, 32'h0);
    issue(3'b001, 32'h0, 32'h0, 32'h200);
    issue(3'b001, 32'h0, 32'h0, 32'h202);
    idle_cycles(4);

    // randomized commands, back-to-back and with gaps
    for (int i = 0; i < 400; i++) begin
      set_wait(0, $urandom_range(0, 2));
      issue(3'($urandom_range(1, 7)), 32'($urandom_range(0, 15)), $urandom,
            32'($urandom_range(0, 63)));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end

    for (int i = 0; i < 100 && (exp_txn_q.size() + exp_mdr_q.size() + exp_mbr_q.size()) != 0; i++)
      idle_cycles(1);
    idle_cycles(2);
    chk("txn_q_drained", 32'(exp_txn_q.size()), 32'h0);
    chk("mdr_q_drained", 32'(exp_mdr_q.size()), 32'h0);
    chk("mbr_q_drained", 32'(exp_mbr_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
